// File: rtl/execute_md.sv
// MIPS execute stage: forwarding, ALU, dest select, E->M register, iterative mul/div with HI/LO.
// Latency: ALU 1 cycle into M; MD busy DATA_W+1 cycles (DIV, and MULT unless EXECUTE_FAST_MUL_EN, then 1).
// Backpressure: md_stall_o holds E/D/F while an MD op meets a busy unit; M receives a bubble meanwhile.
module execute_md #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              reg_write_e_i,
    input  logic              mem_write_e_i,
    input  logic              mem_to_reg_e_i,
    input  logic              reg_dst_e_i,
    input  logic              link_e_i,
    input  logic [1:0]        alu_src_e_i,
    input  logic [3:0]        alu_control_e_i,
    input  logic [3:0]        md_op_e_i,
    input  logic [DATA_W-1:0] reg_data_1_e_i,
    input  logic [DATA_W-1:0] reg_data_2_e_i,
    input  logic [REG_AW-1:0] rt_e_i,
    input  logic [REG_AW-1:0] rd_e_i,
    input  logic [4:0]        shamt_e_i,
    input  logic [DATA_W-1:0] sign_imm_e_i,
    input  logic [DATA_W-1:0] result_w_i,
    input  logic [1:0]        forward_a_e_i,
    input  logic [1:0]        forward_b_e_i,
    output logic [REG_AW-1:0] write_reg_e_o,
    output logic              md_busy_o,
    output logic              md_stall_o,
    output logic              reg_write_m_o,
    output logic              mem_write_m_o,
    output logic              mem_to_reg_m_o,
    output logic [DATA_W-1:0] alu_out_m_o,
    output logic [DATA_W-1:0] write_data_m_o,
    output logic [REG_AW-1:0] write_reg_m_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} md_state_t;

    md_state_t           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [DATA_W-1:0]   opnd_q;
    logic                neg_lo_q, neg_hi_q, is_div_q;
    logic [DATA_W-1:0]   hi_q, lo_q;

    logic [DATA_W-1:0] fwd_a, fwd_b, src_a, src_b, alu_res, e_result;

    always_comb begin
        fwd_a = reg_data_1_e_i;
        fwd_b = reg_data_2_e_i;
        case (forward_a_e_i)
            2'd1:    fwd_a = result_w_i;
            2'd2:    fwd_a = alu_out_m_o;
            default: fwd_a = reg_data_1_e_i;
        endcase
        case (forward_b_e_i)
            2'd1:    fwd_b = result_w_i;
            2'd2:    fwd_b = alu_out_m_o;
            default: fwd_b = reg_data_2_e_i;
        endcase
    end

    assign src_a = alu_src_e_i[1] ? {{(DATA_W-5){1'b0}}, shamt_e_i} : fwd_a;
    assign src_b = alu_src_e_i[0] ? sign_imm_e_i : fwd_b;

    always_comb begin
        alu_res = '0;
        case (alu_control_e_i)
            4'b0000: alu_res = src_a & src_b;
            4'b0001: alu_res = src_a | src_b;
            4'b0010: alu_res = src_a + src_b;
            4'b0011: alu_res = src_a ^ src_b;
            4'b0100: alu_res = ~(src_a | src_b);
            4'b0110: alu_res = src_a - src_b;
            4'b0111: alu_res = {{(DATA_W-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            4'b1000: alu_res = src_b << src_a[4:0];
            4'b1001: alu_res = src_b >> src_a[4:0];
            4'b1010: alu_res = $unsigned($signed(src_b) >>> src_a[4:0]);
            4'b1011: alu_res = {{(DATA_W-1){1'b0}}, src_a < src_b};
            4'b1100: alu_res = {src_b[DATA_W/2-1:0], {(DATA_W/2){1'b0}}};
            default: alu_res = '0;
        endcase
    end

    assign write_reg_e_o = link_e_i    ? {REG_AW{1'b1}} :
                           reg_dst_e_i ? rd_e_i : rt_e_i;

    assign e_result = (md_op_e_i == MD_MFHI) ? hi_q :
                      (md_op_e_i == MD_MFLO) ? lo_q : alu_res;

    // MD operand preparation: signed ops work on magnitudes, sign applied in FIX
    logic is_mul_op, is_div_op, signed_op, md_start, mt_fire, md_nowrite;
    logic a_neg, b_neg;
    logic [DATA_W-1:0] a_abs, b_abs;

    assign is_mul_op  = (md_op_e_i == MD_MULT) || (md_op_e_i == MD_MULTU);
    assign is_div_op  = (md_op_e_i == MD_DIV)  || (md_op_e_i == MD_DIVU);
    assign signed_op  = (md_op_e_i == MD_MULT) || (md_op_e_i == MD_DIV);
    assign md_start   = !md_busy_o && (is_mul_op || is_div_op);
    assign mt_fire    = !md_stall_o && ((md_op_e_i == MD_MTHI) || (md_op_e_i == MD_MTLO));
    assign md_nowrite = is_mul_op || is_div_op ||
                        (md_op_e_i == MD_MTHI) || (md_op_e_i == MD_MTLO);
    assign a_neg = signed_op & fwd_a[DATA_W-1];
    assign b_neg = signed_op & fwd_b[DATA_W-1];
    assign a_abs = a_neg ? -fwd_a : fwd_a;
    assign b_abs = b_neg ? -fwd_b : fwd_b;

    always_comb begin
        state_d    = state_q;
        md_busy_o  = (state_q != S_IDLE);
        md_stall_o = (state_q != S_IDLE) && (md_op_e_i != 4'd0);
        case (state_q)
            S_IDLE: begin
                if (md_start) begin
`ifdef EXECUTE_FAST_MUL_EN
                    state_d = is_mul_op ? S_FIX : S_DIV;
`else
                    state_d = is_mul_op ? S_MUL : S_DIV;
`endif
                end
            end
            S_MUL, S_DIV: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            S_FIX:        state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
    logic [DATA_W:0]     mul_sum, div_trial;
    logic [DATA_W-1:0]   div_diff;
    logic                div_ge;
    logic [2*DATA_W-1:0] mul_next, div_next, prod_fix;
    logic [DATA_W-1:0]   q_raw, r_raw, hi_fix, lo_fix;

    assign mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next  = {mul_sum, acc_q[DATA_W-1:1]};
    assign div_trial = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    assign div_ge    = div_trial >= {1'b0, opnd_q};
    assign div_diff  = div_trial[DATA_W-1:0] - opnd_q;
    assign div_next  = div_ge ? {div_diff, acc_q[DATA_W-2:0], 1'b1}
                              : {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};

    assign q_raw    = acc_q[DATA_W-1:0];
    assign r_raw    = acc_q[2*DATA_W-1:DATA_W];
    assign prod_fix = neg_lo_q ? -acc_q : acc_q;

    always_comb begin
        hi_fix = prod_fix[2*DATA_W-1:DATA_W];
        lo_fix = prod_fix[DATA_W-1:0];
        if (is_div_q) begin
            // a zero divisor still yields all-ones quotient and remainder = dividend
            lo_fix = (opnd_q == '0) ? '1 : (neg_lo_q ? -q_raw : q_raw);
            hi_fix = neg_hi_q ? -r_raw : r_raw;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (md_start) begin
                        cnt_q    <= CNT_W'(DATA_W);
                        neg_lo_q <= a_neg ^ b_neg;
                        neg_hi_q <= a_neg;
                        is_div_q <= is_div_op;
                        if (is_div_op) begin
                            acc_q  <= {{DATA_W{1'b0}}, a_abs};
                            opnd_q <= b_abs;
                        end else begin
`ifdef EXECUTE_FAST_MUL_EN
                            acc_q  <= {{DATA_W{1'b0}}, a_abs} * {{DATA_W{1'b0}}, b_abs};
`else
                            acc_q  <= {{DATA_W{1'b0}}, b_abs};
`endif
                            opnd_q <= a_abs;
                        end
                    end
                    if (mt_fire && md_op_e_i == MD_MTHI) hi_q <= fwd_a;
                    if (mt_fire && md_op_e_i == MD_MTLO) lo_q <= fwd_a;
                end
                S_MUL: begin
                    acc_q <= mul_next;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                S_DIV: begin
                    acc_q <= div_next;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                S_FIX: begin
                    hi_q <= hi_fix;
                    lo_q <= lo_fix;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni || md_stall_o) begin
            reg_write_m_o  <= 1'b0;
            mem_write_m_o  <= 1'b0;
            mem_to_reg_m_o <= 1'b0;
            alu_out_m_o    <= '0;
            write_data_m_o <= '0;
            write_reg_m_o  <= '0;
        end else begin
            reg_write_m_o  <= reg_write_e_i & ~md_nowrite;
            mem_write_m_o  <= mem_write_e_i & ~md_nowrite;
            mem_to_reg_m_o <= mem_to_reg_e_i;
            alu_out_m_o    <= e_result;
            write_data_m_o <= fwd_b;
            write_reg_m_o  <= write_reg_e_o;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_execute_md.sv
// Directed-vector bench for execute_md; expectations queued with a due cycle, checked by a monitor.
module tb_execute_md;
    localparam int W = 32;
`ifdef EXECUTE_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        reg_write_e, mem_write_e, mem_to_reg_e, reg_dst_e, link_e;
    logic [1:0]  alu_src_e, forward_a_e, forward_b_e;
    logic [3:0]  alu_control_e, md_op_e;
    logic [31:0] reg_data_1_e, reg_data_2_e, sign_imm_e, result_w;
    logic [4:0]  rt_e, rd_e, shamt_e;
    logic [4:0]  write_reg_e, write_reg_m;
    logic        md_busy, md_stall, reg_write_m, mem_write_m, mem_to_reg_m;
    logic [31:0] alu_out_m, write_data_m, hi, lo;

    execute_md #(.DATA_W(W), .REG_AW(5)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .reg_write_e_i(reg_write_e), .mem_write_e_i(mem_write_e), .mem_to_reg_e_i(mem_to_reg_e),
        .reg_dst_e_i(reg_dst_e), .link_e_i(link_e), .alu_src_e_i(alu_src_e),
        .alu_control_e_i(alu_control_e), .md_op_e_i(md_op_e),
        .reg_data_1_e_i(reg_data_1_e), .reg_data_2_e_i(reg_data_2_e),
        .rt_e_i(rt_e), .rd_e_i(rd_e), .shamt_e_i(shamt_e), .sign_imm_e_i(sign_imm_e),
        .result_w_i(result_w), .forward_a_e_i(forward_a_e), .forward_b_e_i(forward_b_e),
        .write_reg_e_o(write_reg_e), .md_busy_o(md_busy), .md_stall_o(md_stall),
        .reg_write_m_o(reg_write_m), .mem_write_m_o(mem_write_m), .mem_to_reg_m_o(mem_to_reg_m),
        .alu_out_m_o(alu_out_m), .write_data_m_o(write_data_m), .write_reg_m_o(write_reg_m),
        .hi_o(hi), .lo_o(lo)
    );

    // kind 0: M stage, 1: HI/LO, 2: busy/stall
    typedef struct {
        int          due;
        int          kind;
        string       name;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [4:0]  ereg;
        logic [2:0]  ectl;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input exp_t e);
        n_vec++;
        case (e.kind)
            0: if (alu_out_m !== e.e0 || write_data_m !== e.e1 || write_reg_m !== e.ereg ||
                   {reg_write_m, mem_write_m, mem_to_reg_m} !== e.ectl) begin
                n_bad++;
                $display("FAIL %s: got alu=%h wd=%h reg=%0d ctl=%b, want alu=%h wd=%h reg=%0d ctl=%b",
                         e.name, alu_out_m, write_data_m, write_reg_m,
                         {reg_write_m, mem_write_m, mem_to_reg_m}, e.e0, e.e1, e.ereg, e.ectl);
            end
            1: if (hi !== e.e0 || lo !== e.e1) begin
                n_bad++;
                $display("FAIL %s: got hi=%h lo=%h, want hi=%h lo=%h", e.name, hi, lo, e.e0, e.e1);
            end
            default: if ({md_busy, md_stall} !== e.ectl[1:0]) begin
                n_bad++;
                $display("FAIL %s: got busy/stall=%b, want %b", e.name, {md_busy, md_stall}, e.ectl[1:0]);
            end
        endcase
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                chk(sb[i]);
                sb.delete(i);
            end
        end
    end

    task automatic push(input string nm, input int dly, input int kind, input logic [31:0] e0,
                        input logic [31:0] e1, input logic [4:0] r, input logic [2:0] ctl);
        exp_t e;
        e.due = cyc + dly; e.kind = kind; e.name = nm;
        e.e0 = e0; e.e1 = e1; e.ereg = r; e.ectl = ctl;
        sb.push_back(e);
    endtask

    task automatic exp_m(input string nm, input int dly, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] r, input logic [2:0] ctl);
        push(nm, dly, 0, alu, wd, r, ctl);
    endtask

    task automatic exp_hl(input string nm, input int dly, input logic [31:0] h, input logic [31:0] l);
        push(nm, dly, 1, h, l, 5'd0, 3'd0);
    endtask

    task automatic exp_st(input string nm, input int dly, input logic busy, input logic stall);
        push(nm, dly, 2, 32'd0, 32'd0, 5'd0, {1'b0, busy, stall});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        reg_write_e = 0; mem_write_e = 0; mem_to_reg_e = 0; reg_dst_e = 0; link_e = 0;
        alu_src_e = 0; forward_a_e = 0; forward_b_e = 0; alu_control_e = 0; md_op_e = 0;
        reg_data_1_e = 0; reg_data_2_e = 0; sign_imm_e = 0; result_w = 0;
        rt_e = 0; rd_e = 0; shamt_e = 0;
    endtask

    task automatic alu_op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        nop();
        alu_control_e = ctl; reg_data_1_e = a; reg_data_2_e = b;
        reg_write_e = 1; reg_dst_e = 1; rd_e = rd;
    endtask

    task automatic md_run(input string nm, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                          input int lat);
        nop();
        md_op_e = op; reg_data_1_e = a; reg_data_2_e = b;
        exp_hl(nm, lat + 1, h, l);
        exp_st({nm, "_busy"}, 1, 1'b1, 1'b0);
        exp_st({nm, "_idle"}, lat + 1, 1'b0, 1'b0);
        step();
        nop();
        repeat (lat + 1) step();
    endtask

    initial begin
        nop();
        rst_n = 0;
        step(); step();
        exp_m("rst_m", 0, 0, 0, 0, 3'b000);
        exp_hl("rst_hilo", 0, 0, 0);
        exp_st("rst_st", 0, 1'b0, 1'b0);
        step();
        rst_n = 1;

        // ALU and forwarding
        alu_op(4'b0010, 32'd2, 32'd3, 5'd3);
        exp_m("add_plain", 1, 32'd5, 32'd3, 5'd3, 3'b100);
        step();
        alu_op(4'b0010, 32'd100, 32'd200, 5'd4);
        forward_a_e = 2; forward_b_e = 1; result_w = 32'd7;
        exp_m("add_fwd", 1, 32'd12, 32'd7, 5'd4, 3'b100);
        step();
        alu_op(4'b0010, 32'd10, 32'd20, 5'd5);
        forward_a_e = 3; result_w = 32'd99;
        exp_m("add_fwd_rsvd", 1, 32'd30, 32'd20, 5'd5, 3'b100);
        step();
        alu_op(4'b0010, 32'd1000, 32'h55, 5'd9);
        reg_dst_e = 0; rt_e = 5'd6; alu_src_e = 2'b11; shamt_e = 5'd4; sign_imm_e = 32'hFFFF_FFF0;
        exp_m("add_imm_shamt", 1, 32'hFFFF_FFF4, 32'h55, 5'd6, 3'b100);
        step();
        alu_op(4'b0110, 32'd10, 32'd3, 5'd7);
        forward_b_e = 3; result_w = 32'd99;
        exp_m("sub_rsvd_b", 1, 32'd7, 32'd3, 5'd7, 3'b100);
        step();
        alu_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd2);
        exp_m("slt_signed", 1, 32'd1, 32'd1, 5'd2, 3'b100);
        step();

        // reset mid-stream while M holds a live result
        alu_op(4'b0010, 32'd1, 32'd1, 5'd9);
        exp_m("pre_rst_add", 1, 32'd2, 32'd1, 5'd9, 3'b100);
        step(); step();
        rst_n = 0;
        exp_m("midrst_m", 0, 0, 0, 0, 3'b000);
        step();
        rst_n = 1;
        nop();

        // MULT then MFLO stalls until HI/LO written
        nop();
        md_op_e = 4'd1; reg_data_1_e = 32'hFFFF_FFFF; reg_data_2_e = 32'd3;
        alu_control_e = 4'b0010; reg_write_e = 1; reg_dst_e = 1; rd_e = 5'd0;
        exp_m("mult_pass", 1, 32'd2, 32'd3, 5'd0, 3'b000);
        exp_hl("mult_hilo_early", MUL_LAT, 32'd0, 32'd0);
        exp_hl("mult_hilo", MUL_LAT + 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        exp_st("mult_busy", 1, 1'b1, 1'b1);
        step();
        nop();
        md_op_e = 4'd6; reg_write_e = 1; reg_dst_e = 1; rd_e = 5'd8;
        exp_m("mflo_bubble", 1, 0, 0, 0, 3'b000);
        exp_st("mflo_stall_last", MUL_LAT - 1, 1'b1, 1'b1);
        exp_st("mflo_release", MUL_LAT, 1'b0, 1'b0);
        exp_m("mflo_result", MUL_LAT + 1, 32'hFFFF_FFFD, 32'd0, 5'd8, 3'b100);
        repeat (MUL_LAT + 1) step();
        nop();

        // MULTU with an ALU op flowing during busy
        md_op_e = 4'd2; reg_data_1_e = 32'hFFFF_FFFF; reg_data_2_e = 32'd3;
        exp_hl("multu_hilo", MUL_LAT + 1, 32'd2, 32'hFFFF_FFFD);
        exp_st("multu_busy", 1, 1'b1, 1'b0);
        step();
        alu_op(4'b0010, 32'd40, 32'd2, 5'd10);
        exp_m("add_while_busy", 1, 32'd42, 32'd2, 5'd10, 3'b100);
        step();
        nop();
        repeat (MUL_LAT + 2) step();

        // divides
        md_run("div_neg",     4'd3, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        md_run("divu_zero",   4'd4, 32'd7,         32'd0,          32'd7,         32'hFFFF_FFFF, DIV_LAT);
        md_run("div_ovf",     4'd3, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, DIV_LAT);
        md_run("div_zero_sg", 4'd3, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF, DIV_LAT);

        // MTHI stalls behind a DIVU, then MFHI / MTLO / MFLO
        nop();
        md_op_e = 4'd4; reg_data_1_e = 32'd100; reg_data_2_e = 32'd7;
        step();
        nop();
        md_op_e = 4'd7; reg_data_1_e = 32'h1234; alu_control_e = 4'b0001;
        reg_write_e = 1; rt_e = 5'd12;
        exp_st("mthi_stall", 0, 1'b1, 1'b1);
        exp_m("mthi_bubble", 1, 0, 0, 0, 3'b000);
        exp_hl("divu_then_mthi", DIV_LAT + 1, 32'h1234, 32'd14);
        exp_m("mthi_pass", DIV_LAT + 1, 32'h1234, 32'd0, 5'd12, 3'b000);
        repeat (DIV_LAT + 1) step();
        nop();
        md_op_e = 4'd5; reg_write_e = 1; reg_dst_e = 1; rd_e = 5'd13;
        exp_m("mfhi", 1, 32'h1234, 32'd0, 5'd13, 3'b100);
        step();
        nop();
        md_op_e = 4'd8; reg_data_1_e = 32'hABCD;
        exp_hl("mtlo", 1, 32'h1234, 32'hABCD);
        step();
        nop();
        md_op_e = 4'd6; reg_write_e = 1; reg_dst_e = 1; rd_e = 5'd14;
        exp_m("mflo_mtlo", 1, 32'hABCD, 32'd0, 5'd14, 3'b100);
        step();

        // JAL destination override
        alu_op(4'b0010, 32'h400, 32'd0, 5'd3);
        link_e = 1; alu_src_e = 2'b01; sign_imm_e = 32'd8;
        exp_m("jal", 1, 32'h408, 32'd0, 5'd31, 3'b100);
        step();

        // reset just before DIV step 10
        nop();
        md_op_e = 4'd3; reg_data_1_e = 32'd100; reg_data_2_e = 32'd7;
        step();
        nop();
        repeat (9) step();
        rst_n = 0;
        exp_st("rst_div_st", 0, 1'b0, 1'b0);
        exp_hl("rst_div_hl", 0, 32'd0, 32'd0);
        step();
        rst_n = 1;
        exp_hl("no_late_write", 40, 32'd0, 32'd0);
        exp_st("no_late_busy", 40, 1'b0, 1'b0);
        repeat (41) step();

        md_run("mult_6x7", 4'd1, 32'd6, 32'd7, 32'd0, 32'd42, MUL_LAT);

        repeat (3) step();
        while (sb.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: never checked, due cycle %0d, now %0d", sb[0].name, sb[0].due, cyc);
            void'(sb.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
